instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the instruction-memory word-address width.
REQ-002 SHALL have parameter BASE_ADDR, default 0, meaning the first word address written after reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: the encode request is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the request this cycle.
REQ-007 SHALL have port in_cls, input, 4 bits: instruction class; 0=R, 1=I-ALU, 2=LOAD, 3=STORE, 4=BRANCH, 5=JAL, 6=JALR, 7=LUI, 8=AUIPC; 9-15 are illegal.
REQ-008 SHALL have ports in_rd, in_rs1 and in_rs2, input, 5 bits each: register indices.
REQ-009 SHALL have port in_funct3, input, 3 bits: the funct3 field.
REQ-010 SHALL have port in_f7b5, input, 1 bit: instruction bit 30, selecting SUB/SRA/SRAI.
REQ-011 SHALL have port in_imm, input, 32 bits: the immediate, byte offset, sign-extended.
REQ-012 SHALL have port out_valid, input/output role output, 1 bit: out_instr and out_addr hold a write.
REQ-013 SHALL have port out_ready, input, 1 bit: the memory side accepts the write.
REQ-014 SHALL have port out_instr, output, 32 bits: the encoded RV32I word.
REQ-015 SHALL have port out_addr, output, ADDR_W bits: the word address for out_instr.
REQ-016 SHALL have port err, output, 1 bit: sticky flag set by an illegal class.
REQ-017 SHALL have port err_clr, input, 1 bit: clears err.

Function
REQ-018 SHALL make a request transfer when in_valid and in_ready are both 1, and a write transfer when out_valid and out_ready are both 1.
REQ-019 SHALL drive in_ready = !out_valid || out_ready (single output register, no combinational path from in_valid to out_valid).
REQ-020 SHALL present an accepted legal request as out_valid=1 on the next cycle (latency 1), allowing full throughput of one word per cycle.
REQ-021 SHALL hold out_instr, out_addr and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL encode opcodes as R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
REQ-023 SHALL encode R-type as {0,f7b5,00000,rs2,rs1,funct3,rd,op}.
REQ-024 SHALL encode I-ALU/LOAD/JALR as {imm[11:0],rs1,funct3,rd,op}, with JALR funct3 forced to 000.
REQ-025 SHALL, for I-ALU with funct3 001 or 101, set bits[31:25] to {0,f7b5,00000} and bits[24:20] to imm[4:0].
REQ-026 SHALL encode STORE as {imm[11:5],rs2,rs1,funct3,imm[4:0],op}.
REQ-027 SHALL encode BRANCH as {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}, with imm[0] ignored.
REQ-028 SHALL encode JAL as {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}, with imm[0] ignored.
REQ-029 SHALL encode LUI/AUIPC as {imm[31:12],rd,op}.
REQ-030 SHALL ignore fields unused by the class (rs2 for I-type, rd for STORE/BRANCH, etc.).
REQ-031 SHALL accept a request with an illegal class (in_ready rule unchanged), load nothing, leave out_valid unchanged, and set err on the next cycle.
REQ-032 SHALL load out_addr from an address counter when a legal request is loaded; the counter increments by 1 per loaded legal request and wraps from 2^ADDR_W-1 to 0.
REQ-033 SHALL give set priority over clear when err_clr and an illegal acceptance occur in the same cycle (err stays 1).

Reset
REQ-034 SHALL, while rst=1, asynchronously force out_valid=0, out_instr=0, err=0, counter=BASE_ADDR and out_addr=BASE_ADDR; in_ready then reads 1.
REQ-035 SHALL discard a pending write on reset mid-operation, and the first request after reset SHALL be written to BASE_ADDR.

Verification
REQ-036 SHALL cover: cls=1, rd=1, rs1=0, f3=0, imm=5 -> out_instr=0x00500093, out_addr=0; then cls=0, rd=3, rs1=1, rs2=2, f7b5=1 -> 0x402081B3 at addr 1.
REQ-037 SHALL cover: cls=3, rs1=1, rs2=2, f3=010, imm=8 -> 0x0020A423; cls=5, rd=1, imm=8 -> 0x008000EF; cls=7, rd=5, imm=0x12345000 -> 0x123452B7.
REQ-038 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, no request lost, and order preserved after release.
REQ-039 SHALL cover: ADDR_W=2 with 5 legal requests -> addresses 0,1,2,3,0.
REQ-040 SHALL cover: cls=12 -> no write, counter unchanged, err=1; err_clr in the same cycle as another illegal request -> err stays 1.
REQ-041 SHALL cover: rst pulsed while out_valid=1 and out_ready=0 -> out_valid=0 immediately, and the next write goes to BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: turns a decoded request into a 32-bit word and
// streams it, with an auto-incrementing word address, to instruction memory.
module instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_cls,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_f7b5,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  input  logic              err_clr
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic              out_valid_q;
  logic [31:0]       out_instr_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              err_q;

  logic [31:0]       instr_d;
  logic              legal;
  logic              accept;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign legal     = (in_cls <= 4'd8);

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign err       = err_q;

  always_comb begin
    instr_d = '0;
    case (in_cls)
      4'd0: instr_d = {1'b0, in_f7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      4'd1: begin
        // Shift-immediates carry SRAI/SRLI selection in the upper funct7 bits
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
          instr_d = {1'b0, in_f7b5, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_IALU};
        else
          instr_d = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IALU};
      end
      4'd2: instr_d = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
      4'd3: instr_d = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
      4'd4: instr_d = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], OP_BRANCH};
      4'd5: instr_d = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
      4'd6: instr_d = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
      4'd7: instr_d = {in_imm[31:12], in_rd, OP_LUI};
      4'd8: instr_d = {in_imm[31:12], in_rd, OP_AUIPC};
      default: instr_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= BASE;
      cnt_q       <= BASE;
      err_q       <= 1'b0;
    end else begin
      if (accept && legal) begin
        out_valid_q <= 1'b1;
        out_instr_q <= instr_d;
        out_addr_q  <= cnt_q;
        cnt_q       <= cnt_q + ADDR_W'(1);
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      // An illegal acceptance wins over a same-cycle clear
      if (accept && !legal)
        err_q <= 1'b1;
      else if (err_clr)
        err_q <= 1'b0;
    end
  end

endmodule
